// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU controller: one alu1 slice reused LSB-first over WIDTH clocks.
// Optional status flags are compiled in with `define SERIAL_ALU_FLAGS_EN.

module alu1 (
  output logic       out,
  output logic       carryout,
  input  logic       A,
  input  logic       B,
  input  logic       carryin,
  input  logic [2:0] control
);

  logic b_eff;
  logic sum;

  // Subtraction inverts B; the controller seeds carryin with 1 to form two's complement.
  assign b_eff    = B ^ (control == 3'd3);
  assign sum      = A ^ b_eff ^ carryin;
  assign carryout = (A & b_eff) | (A & carryin) | (b_eff & carryin);

  always_comb begin
    out = 1'b0;
    unique case (control)
      3'd2, 3'd3: out = sum;
      3'd4:       out = A & B;
      3'd5:       out = A | B;
      3'd6:       out = ~(A | B);
      3'd7:       out = A ^ B;
      default:    out = 1'b0;
    endcase
  end

endmodule

module serial_alu_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             error,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] result_q;
  logic [CntW-1:0]  cnt_q;
  logic             carry_q;
  logic             error_q;

  logic             slice_out;
  logic             slice_cout;
  logic             op_illegal;
  logic             last_bit;
  logic [WIDTH-1:0] result_next;

  alu1 u_alu1 (
    .out      (slice_out),
    .carryout (slice_cout),
    .A        (a_q[0]),
    .B        (b_q[0]),
    .carryin  (carry_q),
    .control  (op_q)
  );

  assign op_illegal  = (op[2:1] == 2'b00);
  assign last_bit    = (state_q == StRun) && (cnt_q == CntLast);
  assign result_next = {slice_out, result_q[WIDTH-1:1]};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_valid) begin
            op_q    <= op;
            a_q     <= a;
            b_q     <= b;
            cnt_q   <= '0;
            carry_q <= (op == 3'd3);
            if (op_illegal) begin
              result_q <= '0;
              error_q  <= 1'b1;
              state_q  <= StDone;
            end else begin
              error_q <= 1'b0;
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          a_q      <= a_q >> 1;
          b_q      <= b_q >> 1;
          result_q <= result_next;
          carry_q  <= slice_cout;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          if (result_ready) begin
            error_q <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign start_ready  = (state_q == StIdle);
  assign result_valid = (state_q == StDone);
  assign result       = result_q;
  assign error        = error_q;

`ifdef SERIAL_ALU_FLAGS_EN
  logic overflow_q;
  logic zero_q;
  logic negative_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
    end else if ((state_q == StIdle) && start_valid && op_illegal) begin
      overflow_q <= 1'b0;
      zero_q     <= 1'b1;
      negative_q <= 1'b0;
    end else if (last_bit) begin
      // carry_q holds the MSB carry-in on the final serial step.
      overflow_q <= (op_q[2:1] == 2'b01) & (carry_q ^ slice_cout);
      zero_q     <= (result_next == '0);
      negative_q <= slice_out;
    end else if ((state_q == StDone) && result_ready) begin
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
    end
  end

  assign overflow = overflow_q;
  assign zero     = zero_q;
  assign negative = negative_q;
`else
  assign overflow = 1'b0;
  assign zero     = 1'b0;
  assign negative = 1'b0;
`endif

endmodule

// File: doc/serial_alu_ctrl.md
SERIAL_ALU_CTRL -- requirements
Module: serial_alu_ctrl

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, operand/result width in bits (legal range 2..64).
REQ-002 The block SHALL have one clock and a synchronous, active-high reset, with clock and reset as the first two ports.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start_valid  input  1  requester presents an operation.
REQ-006 start_ready  output  1  controller can accept an operation.
REQ-007 op  input  3  ALU control code: 2 add, 3 sub, 4 and, 5 or, 6 nor, 7 xor; 0 and 1 are illegal.
REQ-008 a, b  input  WIDTH  operands.
REQ-009 result  output  WIDTH  computed word.
REQ-010 result_valid  output  1  result and flags are valid.
REQ-011 result_ready  input  1  consumer accepts the result.
REQ-012 error  output  1  illegal op was presented.
REQ-013 overflow, zero, negative  output  1 each  status flags, present only per REQ-031.

Function
REQ-014 The block SHALL instantiate the existing 1-bit ALU slice alu1(out, carryout, A, B, carryin, control) once and compute every word operation bit-serially, LSB first, one bit per clock.
REQ-015 The FSM SHALL have states IDLE, RUN and DONE, with IDLE as the reset state.
REQ-016 In IDLE, start_ready SHALL be 1; in RUN and DONE, start_ready SHALL be 0.
REQ-017 A transfer SHALL occur on an edge where start_valid && start_ready; op, a and b SHALL be latched on that edge, the bit counter cleared, and the carry flop loaded with 1 for op=3 and with 0 otherwise.
REQ-018 On a legal op, the transfer edge SHALL move the FSM to RUN.
REQ-019 On op 0 or 1, the transfer edge SHALL move the FSM directly to DONE with result=0 and error=1, with no RUN cycles.
REQ-020 In RUN, each edge SHALL drive the slice with the a-shift LSB, the b-shift LSB, the carry flop and the latched op, shift the slice output into result from the MSB end, load carryout into the carry flop, and increment the counter.
REQ-021 After exactly WIDTH RUN edges, the FSM SHALL enter DONE, so result_valid rises WIDTH edges after the transfer edge.
REQ-022 Word-level results SHALL be: a+b, a-b (two's complement), a&b, a|b, ~(a|b), a^b, each truncated to WIDTH bits.
REQ-023 In DONE, result_valid SHALL be 1 and result, error and the flags SHALL hold stable until an edge with result_ready=1.
REQ-024 An edge with result_ready=1 in DONE SHALL return the FSM to IDLE; no new operation is accepted on that same edge.
REQ-025 result_ready SHALL be ignored outside DONE, and start_valid SHALL be ignored outside IDLE.
REQ-026 error SHALL be 0 for legal ops.

Reset
REQ-027 Reset SHALL force IDLE on the next edge from any state, including mid-RUN, and discard any in-flight operation.
REQ-028 After reset, the outputs SHALL be: start_ready=1, result_valid=0, result=0, error=0 and all flags 0.
REQ-029 Reset SHALL have priority over start_valid and result_ready on the same edge.

Configuration
REQ-030 The macro SERIAL_ALU_FLAGS_EN SHALL compile the flag logic in or out.
REQ-031 With SERIAL_ALU_FLAGS_EN defined, the flags SHALL be valid in DONE as follows:
- overflow: carry-in of the MSB XOR carryout of the MSB for ops 2 and 3; 0 for logic ops and error.
- zero: 1 when result==0.
- negative: result[WIDTH-1].
REQ-032 With SERIAL_ALU_FLAGS_EN undefined, the overflow, zero and negative ports SHALL still exist but be tied to 0, with no flag registers.

Verification (WIDTH=32)
REQ-033 The bench SHALL cover these scenarios:
- op=2, a=0x7FFFFFFF, b=1 -> result_valid 32 edges after transfer; result=0x80000000, overflow=1, negative=1, zero=0.
- op=3, a=5, b=5 -> result=0, zero=1, overflow=0.
- op=3, a=0x80000000, b=1 -> result=0x7FFFFFFF, overflow=1.
- op=6, a=0, b=0 -> result=0xFFFFFFFF, negative=1; then op=7, a=0xF0F0F0F0, b=0xFFFF0000 -> result=0x0F0FF0F0.
- op=1 -> result_valid one edge after transfer, error=1, result=0.
- result_ready held low 5 cycles in DONE -> outputs stable; reset asserted at RUN edge 10 -> IDLE next edge, start_ready=1, result_valid=0; next op completes correctly.
